// File: rtl/tof_cmd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tof_cmd_pkg
// Description : Shared definitions for the ToF command dispatcher. Holds the
//               host command word layout, opcode values, the 2-bit status
//               encoding reported per channel, and the channel FSM state codes.
// Revision    : 1.0 - initial release
// ============================================================================
package tof_cmd_pkg;

    // Per-channel status as seen by the host
    localparam logic [1:0] c_ST_IDLE  = 2'b00;
    localparam logic [1:0] c_ST_BUSY  = 2'b10;
    localparam logic [1:0] c_ST_DONE  = 2'b01;
    localparam logic [1:0] c_ST_ERROR = 2'b11;

    // Opcodes; CLEAR is consumed by the dispatcher and never forwarded
    localparam logic [3:0] c_OP_NOP     = 4'h0;
    localparam logic [3:0] c_OP_INIT    = 4'h1;
    localparam logic [3:0] c_OP_FW_LOAD = 4'h5;
    localparam logic [3:0] c_OP_CLEAR   = 4'hF;

    // Host command word layout
    localparam int c_OP_LSB    = 0;
    localparam int c_OP_MSB    = 3;
    localparam int c_IDX_LSB   = 8;
    localparam int c_IDX_MSB   = 11;
    localparam int c_BCAST_BIT = 12;
    localparam int c_CMD_Q_W   = 13;

    // Channel FSM state encoding
    localparam logic [2:0] c_CH_IDLE  = 3'd0;
    localparam logic [2:0] c_CH_ISSUE = 3'd1;
    localparam logic [2:0] c_CH_WAIT  = 3'd2;
    localparam logic [2:0] c_CH_DONE  = 3'd3;
    localparam logic [2:0] c_CH_ERROR = 3'd4;

    typedef struct packed {
        logic       bcast;
        logic [3:0] idx;
        logic [3:0] op;
    } cmd_fields_t;

    // Split the captured command bits into their fields
    function automatic cmd_fields_t decode_cmd(input logic [c_CMD_Q_W-1:0] word);
        cmd_fields_t f;
        f.op    = word[c_OP_MSB:c_OP_LSB];
        f.idx   = word[c_IDX_MSB:c_IDX_LSB];
        f.bcast = word[c_BCAST_BIT];
        return f;
    endfunction

    // Host-visible status for a channel FSM state
    function automatic logic [1:0] state_status(input logic [2:0] state);
        logic [1:0] st;
        case (state)
            c_CH_ISSUE, c_CH_WAIT: st = c_ST_BUSY;
            c_CH_DONE:             st = c_ST_DONE;
            c_CH_ERROR:            st = c_ST_ERROR;
            default:               st = c_ST_IDLE;
        endcase
        return st;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tof_cmd_channel.sv
`default_nettype none
// ============================================================================
// Module      : tof_cmd_channel
// Description : One sensor channel: issue/wait/timeout handshake FSM with a
//               saturating timeout counter.
// Ports       : clk, rst          - clock, async active-high reset
//               start             - launch opcode (only pulsed when not busy)
//               clear             - abort / return to IDLE
//               opcode            - opcode to forward on start
//               ready, done, err  - sensor FSM handshake inputs
//               cmd, cmd_valid    - request to the sensor FSM
//               status            - 2-bit host status
//               busy              - channel in ISSUE or WAIT
// Revision    : 1.0 - initial release
// ============================================================================
module tof_cmd_channel
    import tof_cmd_pkg::*;
#(
    parameter int          CMD_W          = 4,
    parameter int          TIMEOUT_W      = 24,
    parameter int unsigned TIMEOUT_CYCLES = 10_000_000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             clear,
    input  logic [CMD_W-1:0] opcode,
    input  logic             ready,
    input  logic             done,
    input  logic             err,
    output logic [CMD_W-1:0] cmd,
    output logic             cmd_valid,
    output logic [1:0]       status,
    output logic             busy
);

    // Counter value at which the wait has lasted TIMEOUT_CYCLES edges
    localparam logic [TIMEOUT_W-1:0] c_TMO_LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

    logic [2:0]           r_state;
    logic [2:0]           w_next_state;
    logic [TIMEOUT_W-1:0] r_count;
    logic [CMD_W-1:0]     r_cmd;
    logic                 w_load;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_CH_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; an abort (clear) overrides any handshake event
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_CH_IDLE, c_CH_DONE, c_CH_ERROR: begin
                if (clear)      w_next_state = c_CH_IDLE;
                else if (start) w_next_state = c_CH_ISSUE;
            end
            c_CH_ISSUE: begin
                if (clear)      w_next_state = c_CH_IDLE;
                else if (ready) w_next_state = c_CH_WAIT;
            end
            c_CH_WAIT: begin
                if (clear)                      w_next_state = c_CH_IDLE;
                else if (err)                   w_next_state = c_CH_ERROR;
                else if (done)                  w_next_state = c_CH_DONE;
                else if (r_count == c_TMO_LAST) w_next_state = c_CH_ERROR;
            end
            default: w_next_state = c_CH_IDLE;
        endcase
    end

    // Outputs decoded from the current state
    always_comb begin
        cmd_valid = (r_state == c_CH_ISSUE);
        busy      = (r_state == c_CH_ISSUE) || (r_state == c_CH_WAIT);
        status    = state_status(r_state);
    end

    // Opcode is latched only on a real launch so it stays stable while valid
    assign w_load = start && !clear &&
                    ((r_state == c_CH_IDLE) || (r_state == c_CH_DONE) ||
                     (r_state == c_CH_ERROR));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cmd <= '0;
        end else if (w_load) begin
            r_cmd <= opcode;
        end
    end

    assign cmd = r_cmd;

    // Counter sits at zero outside WAIT, so WAIT is always entered with zero;
    // inside WAIT it counts up and saturates at the timeout value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (r_state != c_CH_WAIT) begin
            r_count <= '0;
        end else if (r_count != c_TMO_LAST) begin
            r_count <= r_count + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/tof_cmd_dispatcher.sv
`default_nettype none
// ============================================================================
// Module      : tof_cmd_dispatcher
// Description : Decodes the host command word, routes it to one sensor channel
//               or broadcasts it, tracks the sticky reject flag and packs the
//               per-channel status word.
// Ports       : clk, rst      - clock, async active-high reset
//               cmd_in        - host word: [3:0] op, [11:8] index, [12] bcast
//               status_out    - channel k status at [2k+1:2k]
//               cmd_reject    - last new command was refused
//               ch_cmd        - per-channel opcode (CMD_W bits each)
//               ch_cmd_valid  - per-channel request
//               ch_cmd_ready  - per-channel accept
//               ch_done       - per-channel completion pulse
//               ch_err        - per-channel failure pulse
// Revision    : 1.0 - initial release
// ============================================================================
module tof_cmd_dispatcher
    import tof_cmd_pkg::*;
#(
    parameter int          N_SENSORS      = 8,
    parameter int          CMD_W          = 4,
    parameter int          ST_W           = 2,
    parameter int          TIMEOUT_W      = 24,
    parameter int unsigned TIMEOUT_CYCLES = 10_000_000
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [31:0]               cmd_in,
    output logic [ST_W*N_SENSORS-1:0] status_out,
    output logic                      cmd_reject,
    output logic [CMD_W*N_SENSORS-1:0] ch_cmd,
    output logic [N_SENSORS-1:0]      ch_cmd_valid,
    input  logic [N_SENSORS-1:0]      ch_cmd_ready,
    input  logic [N_SENSORS-1:0]      ch_done,
    input  logic [N_SENSORS-1:0]      ch_err
);

    logic [c_CMD_Q_W-1:0] r_cmd_q;
    logic                 r_new_cmd;
    logic                 r_reject;
    cmd_fields_t          w_fields;
    logic                 w_is_clear;
    logic                 w_idx_ok;
    logic                 w_rejected;
    logic [N_SENSORS-1:0] w_target;
    logic [N_SENSORS-1:0] w_busy;
    logic [N_SENSORS-1:0] w_refuse;
    logic                 w_unused_hi;

    assign w_unused_hi = ^cmd_in[31:c_CMD_Q_W];

    // Capture the command and flag it as new in the same edge; channels act
    // on the flagged command one edge later, giving the 2-edge latency.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cmd_q   <= '0;
            r_new_cmd <= 1'b0;
        end else begin
            r_cmd_q   <= cmd_in[c_CMD_Q_W-1:0];
            r_new_cmd <= (cmd_in[c_OP_MSB:c_OP_LSB] != c_OP_NOP) &&
                         (cmd_in[c_CMD_Q_W-1:0] != r_cmd_q);
        end
    end

    assign w_fields   = decode_cmd(r_cmd_q);
    assign w_is_clear = (w_fields.op == c_OP_CLEAR);
    assign w_idx_ok   = w_fields.bcast || (int'(w_fields.idx) < N_SENSORS);

    // CLEAR is never refused by a channel; other opcodes are refused by busy ones
    assign w_refuse   = w_target & w_busy & {N_SENSORS{!w_is_clear}};
    assign w_rejected = !w_idx_ok || (|w_refuse);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_reject <= 1'b0;
        end else if (r_new_cmd) begin
            r_reject <= w_rejected;
        end
    end

    assign cmd_reject = r_reject;

    for (genvar k = 0; k < N_SENSORS; k++) begin : g_ch
        logic [1:0] w_ch_status;
        logic       w_start;
        logic       w_clear;

        assign w_target[k] = r_new_cmd && (w_fields.bcast || (w_fields.idx == 4'(k)));
        assign w_start     = w_target[k] && !w_is_clear && !w_busy[k];
        assign w_clear     = w_target[k] && w_is_clear;

        tof_cmd_channel #(
            .CMD_W          (CMD_W),
            .TIMEOUT_W      (TIMEOUT_W),
            .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
        ) u_channel (
            .clk       (clk),
            .rst       (rst),
            .start     (w_start),
            .clear     (w_clear),
            .opcode    (CMD_W'(w_fields.op)),
            .ready     (ch_cmd_ready[k]),
            .done      (ch_done[k]),
            .err       (ch_err[k]),
            .cmd       (ch_cmd[k*CMD_W +: CMD_W]),
            .cmd_valid (ch_cmd_valid[k]),
            .status    (w_ch_status),
            .busy      (w_busy[k])
        );

        assign status_out[k*ST_W +: ST_W] = ST_W'(w_ch_status);
    end

endmodule
`default_nettype wire

// File: tb/tb_tof_cmd_dispatcher.sv
`timescale 1ns/1ps
module tb_tof_cmd_dispatcher;

    localparam int N  = 8;
    localparam int CW = 4;
    localparam int SW = 2;
    localparam int TW = 24;
    localparam int TC = 16;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [31:0]     cmd_in = 32'h0;
    logic [SW*N-1:0] status_out;
    logic            cmd_reject;
    logic [CW*N-1:0] ch_cmd;
    logic [N-1:0]    ch_cmd_valid;
    logic [N-1:0]    ch_cmd_ready = '1;
    logic [N-1:0]    ch_done = '0;
    logic [N-1:0]    ch_err = '0;

    tof_cmd_dispatcher #(
        .N_SENSORS      (N),
        .CMD_W          (CW),
        .ST_W           (SW),
        .TIMEOUT_W      (TW),
        .TIMEOUT_CYCLES (TC)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_in       (cmd_in),
        .status_out   (status_out),
        .cmd_reject   (cmd_reject),
        .ch_cmd       (ch_cmd),
        .ch_cmd_valid (ch_cmd_valid),
        .ch_cmd_ready (ch_cmd_ready),
        .ch_done      (ch_done),
        .ch_err       (ch_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         ch;
        logic [3:0] op;
    } hs_t;

    hs_t exp_q[$];
    int  checks = 0;
    int  errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int ch, input logic [3:0] op);
        hs_t e;
        e.ch = ch;
        e.op = op;
        exp_q.push_back(e);
    endtask

    initial begin
        fork
            // Monitor: every accepted request must match the next expected one
            forever begin : mon
                hs_t e;
                @(negedge clk);
                if (!rst) begin
                    for (int k = 0; k < N; k++) begin
                        if (ch_cmd_valid[k] && ch_cmd_ready[k]) begin
                            if (exp_q.size() == 0) begin
                                checks++;
                                errors++;
                                $display("FAIL hs_unexpected actual ch=%0d op=%h required=none",
                                         k, ch_cmd[k*CW +: CW]);
                            end else begin
                                e = exp_q.pop_front();
                                check("hs_channel", k, e.ch);
                                check("hs_opcode", 32'(ch_cmd[k*CW +: CW]), 32'(e.op));
                            end
                        end
                    end
                end
            end
        join_none

        // Reset state
        repeat (3) tick();
        rst = 1'b0;
        check("rst_status", 32'(status_out), 32'h0);
        check("rst_valid", 32'(ch_cmd_valid), 32'h0);
        check("rst_reject", 32'(cmd_reject), 32'h0);
        check("rst_ch_cmd", ch_cmd, 32'h0);

        // FW_LOAD on channel 0, ready held high
        cmd_in = 32'h0000_0005;
        push(0, 4'h5);
        tick();
        check("fw_not_yet_valid", 32'(ch_cmd_valid), 32'h0);
        tick();
        check("fw_valid", 32'(ch_cmd_valid), 32'h01);
        check("fw_status_busy", 32'(status_out), 32'h0002);
        check("fw_ch_cmd", 32'(ch_cmd[3:0]), 32'h5);
        tick();
        check("fw_valid_dropped", 32'(ch_cmd_valid), 32'h0);
        check("fw_wait_busy", 32'(status_out), 32'h0002);
        ch_done[0] = 1'b1;
        tick();
        ch_done = '0;
        check("fw_done", 32'(status_out), 32'h0001);

        // INIT on ch3, then repeat it while ch3 waits -> rejected
        cmd_in = 32'h0000_0301;
        push(3, 4'h1);
        tick();
        cmd_in = 32'h0;
        tick();
        check("ch3_busy", 32'(status_out), 32'h0081);
        tick();
        cmd_in = 32'h0000_0301;
        tick();
        tick();
        check("ch3_reject", 32'(cmd_reject), 32'h1);
        check("ch3_untouched", 32'(status_out), 32'h0081);
        check("ch3_no_reissue", 32'(ch_cmd_valid), 32'h0);
        ch_done[3] = 1'b1;
        tick();
        ch_done = '0;
        check("ch3_done", 32'(status_out), 32'h0041);

        // Broadcast INIT, ch5 ready delayed
        cmd_in = 32'h0000_1001;
        ch_cmd_ready = 8'hDF;
        for (int k = 0; k < N; k++) if (k != 5) push(k, 4'h1);
        push(5, 4'h1);
        tick();
        tick();
        check("bc_status_busy", 32'(status_out), 32'hAAAA);
        check("bc_valid_all", 32'(ch_cmd_valid), 32'hFF);
        check("bc_reject_cleared", 32'(cmd_reject), 32'h0);
        tick();
        check("bc_only_ch5_valid", 32'(ch_cmd_valid), 32'h20);
        ch_err[2]  = 1'b1;
        ch_done[2] = 1'b1;
        tick();
        ch_err  = '0;
        ch_done = '0;
        check("bc_ch2_err_wins", 32'(status_out), 32'hAABA);
        repeat (7) tick();
        check("bc_ch5_still_valid", 32'(ch_cmd_valid), 32'h20);
        check("bc_ch5_cmd_stable", 32'(ch_cmd[23:20]), 32'h1);
        ch_cmd_ready = '1;
        tick();
        check("bc_ch5_accepted", 32'(ch_cmd_valid), 32'h0);
        ch_done = 8'hFB;
        tick();
        ch_done = '0;
        check("bc_all_done", 32'(status_out), 32'h5575);

        // Out-of-range index without broadcast
        cmd_in = 32'h0;
        tick();
        cmd_in = 32'h0000_0901;
        tick();
        tick();
        check("idx_reject", 32'(cmd_reject), 32'h1);
        check("idx_no_change", 32'(status_out), 32'h5575);
        check("idx_no_valid", 32'(ch_cmd_valid), 32'h0);

        // Timeout on ch1
        cmd_in = 32'h0000_0101;
        push(1, 4'h1);
        tick();
        tick();
        check("tmo_reject_cleared", 32'(cmd_reject), 32'h0);
        check("tmo_issue", 32'(status_out[3:2]), 32'h2);
        tick();
        check("tmo_in_wait", 32'(ch_cmd_valid), 32'h0);
        repeat (TC - 1) tick();
        check("tmo_before_limit", 32'(status_out[3:2]), 32'h2);
        tick();
        check("tmo_error", 32'(status_out[3:2]), 32'h3);
        cmd_in = 32'h0000_010F;
        tick();
        tick();
        check("clear_to_idle", 32'(status_out[3:2]), 32'h0);

        // CLEAR aborts a channel stuck in ISSUE
        ch_cmd_ready = 8'hFD;
        cmd_in = 32'h0000_0101;
        tick();
        tick();
        check("abort_issue_valid", 32'(ch_cmd_valid), 32'h02);
        cmd_in = 32'h0000_010F;
        tick();
        tick();
        check("abort_valid_low", 32'(ch_cmd_valid), 32'h0);
        check("abort_idle", 32'(status_out[3:2]), 32'h0);

        // Asynchronous reset while ch1 is in ISSUE
        cmd_in = 32'h0000_0101;
        tick();
        tick();
        check("rst2_issue_valid", 32'(ch_cmd_valid), 32'h02);
        #2 rst = 1'b1;
        #1;
        check("rst2_valid", 32'(ch_cmd_valid), 32'h0);
        check("rst2_status", 32'(status_out), 32'h0);
        check("rst2_ch_cmd", ch_cmd, 32'h0);
        cmd_in = 32'h0;
        tick();
        rst = 1'b0;
        tick();
        ch_done[1] = 1'b1;
        tick();
        ch_done = '0;
        check("rst2_late_done", 32'(status_out), 32'h0);
        check("rst2_late_valid", 32'(ch_cmd_valid), 32'h0);
        ch_cmd_ready = '1;

        tick();
        check("scoreboard_empty", exp_q.size(), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tof_cmd_dispatcher.md
# tof_cmd_dispatcher

Parametrised command dispatcher between the Zynq command register and the per-sensor ToF FSMs. Decodes a host command word, routes it to one sensor channel or broadcasts it to all, runs a per-channel issue/wait/timeout handshake, and packs a 2-bit status per channel into the word read back by the host. Replaces the fixed single-sensor command path in `top` and scales to any sensor count.

## Interface
- `N_SENSORS`, 8, number of sensor channels (1..16)
- `CMD_W`, 4, opcode width
- `ST_W`, 2, status bits per channel (fixed encoding below; must be 2)
- `TIMEOUT_W`, 24, width of per-channel timeout counter
- `TIMEOUT_CYCLES`, 24'd10_000_000, cycles in WAIT before ERROR

- `clk`  in  1  single clock; all logic on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `cmd_in`  in  32  host word: [3:0] opcode, [11:8] channel index, [12] broadcast, others ignored
- `status_out`  out  ST_W*N_SENSORS  channel k status at [2k+1:2k]
- `cmd_reject`  out  1  sticky: last new command was refused
- `ch_cmd`  out  CMD_W*N_SENSORS  opcode per channel, stable while valid
- `ch_cmd_valid`  out  N_SENSORS  per-channel request
- `ch_cmd_ready`  in  N_SENSORS  per-channel accept
- `ch_done`  in  N_SENSORS  one-cycle completion pulse
- `ch_err`  in  N_SENSORS  one-cycle failure pulse

## Operation
- Status encoding: 00 IDLE, 10 BUSY, 01 DONE, 11 ERROR.
- `cmd_in[12:0]` registered into `cmd_q` every cycle. New command = opcode ≠ 0 and `cmd_in[12:0]` ≠ `cmd_q`. Host must write opcode 0 (NOP) between identical commands; NOP is never dispatched.
- Index ≥ N_SENSORS with broadcast=0: rejected.
- Opcode 4'hF (CLEAR): internal, never forwarded. Target in DONE/ERROR → IDLE; in ISSUE/WAIT → abort to IDLE (valid drops next cycle, later done/err ignored).
- Other opcodes: target in IDLE/DONE/ERROR → ISSUE; target in ISSUE/WAIT → rejected, channel untouched.
- Broadcast: applied to every channel independently; reject flag set if any channel refuses; accepting channels still start.
- `cmd_reject` set on a rejected new command, cleared on next fully accepted new command.
- Per-channel FSM: IDLE → ISSUE (valid=1, ch_cmd=opcode) → on valid&ready → WAIT (counter cleared) → ch_err → ERROR; ch_done → DONE; counter = TIMEOUT_CYCLES−1 → ERROR. DONE/ERROR hold until next command.
- Same-cycle priority in WAIT: ch_err > ch_done > timeout. ch_done/ch_err outside WAIT ignored.
- Counter saturates; no wrap.

## Timing
- Reset: all channels IDLE, `status_out`=0, `ch_cmd_valid`=0, `ch_cmd`=0, `cmd_reject`=0, `cmd_q`=0.
- `cmd_in` changes before edge E0: captured E0, decision E1, `ch_cmd_valid` and status 10 visible after E1 (2-edge latency).
- Ready sampled with valid at edge E: valid low after E, channel in WAIT.
- Done/err pulse at edge E: status 01/11 visible after E.
- Timeout: ERROR exactly TIMEOUT_CYCLES edges after entering WAIT.
- Reset asserted mid-operation: immediate (asynchronous) return to reset values; pending handshakes dropped.

## Structure
- Package `tof_cmd_pkg`: status encoding constants, opcode constants (NOP=0, INIT=1, FW_LOAD=5, CLEAR=F), command-field bit positions.
- Sub-module `tof_cmd_channel`: one FSM + timeout counter, instantiated N_SENSORS times via generate; top handles decode, edge detect, reject flag, packing.

## Test plan
- Reset, `cmd_in`=0 → status_out=0, no valid, cmd_reject=0.
- `cmd_in`=0x0005 (FW_LOAD ch0), ready held 1 → valid ch0 for one cycle with ch_cmd=5, status[1:0]=10; ch_done pulse → 01; other channels 00.
- `cmd_in`=0x0301 while ch3 in WAIT, then 0x0 then 0x0301 again → second command rejected, cmd_reject=1, ch3 unaffected.
- `cmd_in`=0x1001 (broadcast INIT), N_SENSORS=8, ch5 ready delayed 10 cycles → all status 10, ch5 valid held 10 cycles; err on ch2 and done on ch2 same cycle → ch2 = 11.
- TIMEOUT_CYCLES=16, no done → status 11 exactly 16 edges after WAIT entry; then 0x000F → 00.
- Assert rst while ch1 in ISSUE → valid and status 0 immediately; late ch_done on ch1 ignored.
